// File: rtl/muldiv_iter_if.sv
// Handshake and operand/result bundle for the iterative multiply/divide unit.
interface muldiv_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_iter.sv
// Multi-cycle MULT/MULTU/DIV/DIVU: WIDTH shift-add or restoring-divide iterations on magnitudes,
// then one sign-fix cycle that writes hi/lo and pulses done.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input logic          clk,
  input logic          rst,
  muldiv_iter_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;

  logic               sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign sgn_op = ~bus.op[0];
  assign a_neg  = sgn_op & bus.a[WIDTH-1];
  assign b_neg  = sgn_op & bus.b[WIDTH-1];
  assign a_mag  = a_neg ? -bus.a : bus.a;
  assign b_mag  = b_neg ? -bus.b : bus.b;

  // prod_q holds {upper, multiplier} for multiply and {rem, quot} for divide.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, prod_q[WIDTH-1:1]};

  assign div_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_diff = {1'b0, div_sh} - {2'b00, opnd_q};
  assign div_step = div_diff[WIDTH+1] ? {div_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};

  // With b==0 the remainder ends up as |a|, so the sign-of-a fix restores a unchanged.
  assign mul_res  = neg_res_q ? -prod_q : prod_q;
  assign quot_fix = neg_res_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    opnd_d    = opnd_q;
    prod_d    = prod_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StCalc;
          cnt_d     = '0;
          is_div_d  = bus.op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          bzero_d   = (bus.b == '0);
          if (bus.op[1]) begin
            opnd_d = b_mag;
            prod_d = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            prod_d = {{WIDTH{1'b0}}, b_mag};
          end
        end
      end
      StCalc: begin
        cnt_d  = cnt_q + 1'b1;
        prod_d = is_div_q ? div_step : mul_step;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d  = bzero_q ? {WIDTH{1'b1}} : quot_fix;
          hi_d  = rem_fix;
          dbz_d = bzero_q;
        end else begin
          {hi_d, lo_d} = mul_res;
          dbz_d        = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      opnd_q    <= '0;
      prod_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      opnd_q    <= opnd_d;
      prod_q    <= prod_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Randomised and directed checks of muldiv_iter (WIDTH=32 and WIDTH=8) against an arithmetic model.
module tb_muldiv_iter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  muldiv_iter_if #(.WIDTH(32)) bus32 ();
  muldiv_iter_if #(.WIDTH(8))  bus8 ();

  muldiv_iter #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  muldiv_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  // Reference: plain signed/unsigned integer arithmetic on w-bit values.
  function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] hi,
                                output logic [31:0] lo, output logic dbz);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned ua   = {32'd0, a} & mask;
    longint unsigned ub   = {32'd0, b} & mask;
    longint          sa   = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    longint          sb   = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    longint unsigned p    = 64'd0;
    longint unsigned q    = 64'd0;
    longint unsigned r    = 64'd0;
    dbz = 1'b0;
    if (!op[1]) begin
      p  = op[0] ? ua * ub : longint'(sa * sb);
      lo = 32'(p & mask);
      hi = 32'((p >> w) & mask);
    end else if (ub == 64'd0) begin
      lo  = 32'(mask);
      hi  = 32'(ua);
      dbz = 1'b1;
    end else begin
      if (op[0]) begin
        q = ua / ub;
        r = ua % ub;
      end else begin
        q = longint'(sa / sb);
        r = longint'(sa % sb);
      end
      lo = 32'(q & mask);
      hi = 32'(r & mask);
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      5:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from an idle point (#1 after an edge); lat counts cycles after the start edge.
  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                       output int lat, output int busy_cnt, output logic busy_at_done,
                       output bit timeout);
    bus32.start = 1'b1;
    bus32.op    = op;
    bus32.a     = a;
    bus32.b     = b;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    bus32.op    = 2'($urandom);
    bus32.a     = $urandom;
    bus32.b     = $urandom;
    lat      = 1;
    busy_cnt = 0;
    while (!bus32.done && lat < 200) begin
      if (bus32.busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    timeout      = !bus32.done;
    hi           = bus32.hi;
    lo           = bus32.lo;
    dbz          = bus32.div_by_zero;
    busy_at_done = bus32.busy;
  endtask

  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] hi, output logic [7:0] lo, output logic dbz,
                      output int lat, output int busy_cnt, output bit timeout);
    bus8.start = 1'b1;
    bus8.op    = op;
    bus8.a     = a;
    bus8.b     = b;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    lat      = 1;
    busy_cnt = 0;
    while (!bus8.done && lat < 100) begin
      if (bus8.busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    timeout = !bus8.done;
    hi      = bus8.hi;
    lo      = bus8.lo;
    dbz     = bus8.div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus32.busy, bus32.done, bus32.div_by_zero} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags32: got %b expected 000",
               {bus32.busy, bus32.done, bus32.div_by_zero});
    end
    total++;
    if ({bus32.hi, bus32.lo} !== 64'd0) begin
      bad++;
      $display("FAIL reset_hilo32: got %h expected 0", {bus32.hi, bus32.lo});
    end
    total++;
    if ({bus8.busy, bus8.done, bus8.hi, bus8.lo} !== 18'd0) begin
      bad++;
      $display("FAIL reset_8: got %h expected 0", {bus8.busy, bus8.done, bus8.hi, bus8.lo});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    vec_t        v [10];
    logic [31:0] hi, lo;
    logic        dbz, bad_busy;
    int          lat, bcnt;
    bit          to;
    v[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    v[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    v[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    v[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    v[4] = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    v[5] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    v[6] = '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    v[7] = '{2'b01, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0};
    v[8] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    v[9] = '{2'b10, 32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1};
    for (int i = 0; i < 10; i++) begin
      run32(v[i].op, v[i].a, v[i].b, hi, lo, dbz, lat, bcnt, bad_busy, to);
      total++;
      if (to || {hi, lo, dbz} !== {v[i].hi, v[i].lo, v[i].dbz}) begin
        bad++;
        $display("FAIL directed[%0d]: got hi=%h lo=%h dbz=%b expected hi=%h lo=%h dbz=%b",
                 i, hi, lo, dbz, v[i].hi, v[i].lo, v[i].dbz);
      end
      total++;
      if (lat !== 34 || bcnt !== 33 || bad_busy !== 1'b0) begin
        bad++;
        $display("FAIL directed_timing[%0d]: got lat=%0d busy=%0d busy_at_done=%b expected 34 33 0",
                 i, lat, bcnt, bad_busy);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] hi, lo, a, b, ehi, elo;
    logic [1:0]  op;
    logic        dbz, edbz, bd;
    int          lat, bcnt;
    bit          to;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom);
      a  = pick();
      b  = pick();
      model(32, op, a, b, ehi, elo, edbz);
      run32(op, a, b, hi, lo, dbz, lat, bcnt, bd, to);
      total++;
      if (to || lat != 34 || {hi, lo, dbz} !== {ehi, elo, edbz}) begin
        bad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h dbz=%b lat=%0d expected hi=%h lo=%h dbz=%b lat=34",
                 i, op, a, b, hi, lo, dbz, lat, ehi, elo, edbz);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] hi, lo;
    logic        dbz, bd;
    int          lat, bcnt;
    bit          to;
    run32(2'b11, 32'd100, 32'd7, hi, lo, dbz, lat, bcnt, bd, to);
    for (int i = 0; i < 8; i++) begin
      bus32.op = 2'($urandom);
      bus32.a  = $urandom;
      bus32.b  = $urandom;
      @(posedge clk);
      #1;
      total++;
      if ({bus32.done, bus32.busy, bus32.hi, bus32.lo, bus32.div_by_zero} !==
          {2'b00, 32'd2, 32'd14, 1'b0}) begin
        bad++;
        $display("FAIL hold[%0d]: got done=%b busy=%b hi=%h lo=%h dbz=%b expected 0 0 2 e 0",
                 i, bus32.done, bus32.busy, bus32.hi, bus32.lo, bus32.div_by_zero);
      end
    end
  endtask

  task automatic test_ignore_start();
    int          n_done = 0;
    int          lat    = 0;
    logic [31:0] hi     = '0;
    logic [31:0] lo     = '0;
    bus32.start = 1'b1;
    bus32.op    = 2'b01;
    bus32.a     = 32'd10;
    bus32.b     = 32'd10;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 60; c++) begin
      if (bus32.done) begin
        n_done++;
        if (n_done == 1) begin
          lat = c;
          hi  = bus32.hi;
          lo  = bus32.lo;
        end
      end
      bus32.start = (c == 5);
      bus32.op    = 2'b00;
      bus32.a     = 32'd7;
      bus32.b     = 32'd7;
      @(posedge clk);
      #1;
    end
    bus32.start = 1'b0;
    total++;
    if (n_done !== 1 || lat !== 34) begin
      bad++;
      $display("FAIL ignore_start_timing: got dones=%0d lat=%0d expected 1 34", n_done, lat);
    end
    total++;
    if ({hi, lo} !== {32'd0, 32'd100}) begin
      bad++;
      $display("FAIL ignore_start_value: got hi=%h lo=%h expected 0 64", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo, a, b, ehi, elo;
    logic [1:0]  op;
    logic        dbz, edbz, bd;
    int          lat, bcnt;
    bit          to;
    for (int i = 0; i < 4; i++) begin
      op = 2'($urandom);
      a  = pick();
      b  = pick();
      model(32, op, a, b, ehi, elo, edbz);
      run32(op, a, b, hi, lo, dbz, lat, bcnt, bd, to);
      total++;
      if (to || lat != 34 || {hi, lo, dbz} !== {ehi, elo, edbz}) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got hi=%h lo=%h dbz=%b lat=%0d expected hi=%h lo=%h dbz=%b lat=34",
                 i, hi, lo, dbz, lat, ehi, elo, edbz);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo;
    logic        dbz, bd;
    int          lat, bcnt;
    int          n_done = 0;
    bit          to;
    run32(2'b01, 32'd3, 32'd5, hi, lo, dbz, lat, bcnt, bd, to);
    bus32.start = 1'b1;
    bus32.op    = 2'b01;
    bus32.a     = 32'h1234;
    bus32.b     = 32'h5678;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({bus32.busy, bus32.done, bus32.hi, bus32.lo} !== 66'd0) begin
      bad++;
      $display("FAIL reset_mid_async: got busy=%b done=%b hi=%h lo=%h expected all 0",
               bus32.busy, bus32.done, bus32.hi, bus32.lo);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (bus32.done || bus32.busy) n_done++;
    end
    total++;
    if (n_done !== 0) begin
      bad++;
      $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", n_done);
    end
    run32(2'b00, 32'd6, 32'hFFFF_FFF9, hi, lo, dbz, lat, bcnt, bd, to);
    total++;
    if (to || {hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFD6}) begin
      bad++;
      $display("FAIL reset_mid_recover: got hi=%h lo=%h expected ffffffff ffffffd6", hi, lo);
    end
  endtask

  task automatic test_width8();
    logic [7:0]  hi, lo, a, b;
    logic [31:0] ehi, elo;
    logic [1:0]  op;
    logic        dbz, edbz;
    int          lat, bcnt;
    bit          to;
    run8(2'b01, 8'hFF, 8'hFF, hi, lo, dbz, lat, bcnt, to);
    total++;
    if (to || {hi, lo, dbz} !== {8'hFE, 8'h01, 1'b0} || lat !== 10 || bcnt !== 9) begin
      bad++;
      $display("FAIL w8_multu_ff: got hi=%h lo=%h dbz=%b lat=%0d busy=%0d expected fe 01 0 10 9",
               hi, lo, dbz, lat, bcnt);
    end
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom);
      a  = 8'(pick());
      b  = 8'(pick());
      model(8, op, {24'd0, a}, {24'd0, b}, ehi, elo, edbz);
      run8(op, a, b, hi, lo, dbz, lat, bcnt, to);
      total++;
      if (to || lat != 10 || {hi, lo, dbz} !== {ehi[7:0], elo[7:0], edbz}) begin
        bad++;
        $display("FAIL w8_random[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h dbz=%b lat=%0d expected hi=%h lo=%h dbz=%b lat=10",
                 i, op, a, b, hi, lo, dbz, lat, ehi[7:0], elo[7:0], edbz);
      end
    end
  endtask

  initial begin
    bus32.start = 1'b0;
    bus32.op    = 2'b00;
    bus32.a     = '0;
    bus32.b     = '0;
    bus8.start  = 1'b0;
    bus8.op     = 2'b00;
    bus8.a      = '0;
    bus8.b      = '0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised multi-cycle multiply/divide unit for the CPU-54 datapath.
- Executes MULT, MULTU, DIV and DIVU over WIDTH+2 cycles using a start/busy/done handshake.
- Replaces single-cycle combinational hi/lo generation; hi/lo are held in registers until the next completion.
- Sits beside the ALU; the control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand width in bits (≥4); hi and lo are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when state is IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  input  WIDTH  multiplicand / dividend (rs)
- b  input  WIDTH  multiplier / divisor (rt)
- busy  output  1  high while in CALC or FIX
- done  output  1  one-cycle completion pulse
- hi  output  WIDTH  product upper half / remainder
- lo  output  WIDTH  product lower half / quotient
- div_by_zero  output  1  set with done when a DIV/DIVU had b==0; held until next done

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: state=IDLE; busy, done, div_by_zero = 0; hi, lo = 0; counter = 0. Reset mid-operation aborts it: no done pulse, and the result is discarded.
- States:
  - IDLE -> CALC on start=1. On that edge, latch op, the operand magnitudes (for signed ops, |x| via two's complement; unsigned ops pass through), the result-sign bits, and b==0. Clear the accumulators and the counter.
  - CALC: exactly WIDTH cycles, one iteration per cycle, counter increments. Leave for FIX when counter == WIDTH-1 on the current edge.
    - Multiply: radix-2 shift-add on a 2*WIDTH-bit product register.
    - Divide: restoring division. Shift {rem,quot} left by 1, trial-subtract the divisor from rem, keep the result if non-negative, and set the quotient bit.
  - FIX: one cycle. Apply sign correction and write hi/lo. Move to IDLE with done=1 on the same edge.
- Latency: start sampled on edge E; done is high during the cycle after edge E+WIDTH+1, i.e. WIDTH+2 cycles after E. busy is high from E+1 through the FIX cycle and low while done is high.
- A new start is accepted in the done cycle (back-to-back issue).
- Start while busy is ignored. op, a and b are don't-care after edge E.
- Sign rules:
  - MULT: negate the 2*WIDTH-bit product if sign(a)^sign(b).
  - DIV: negate the quotient if sign(a)^sign(b); the remainder takes the sign of a, with |rem| < |b|.
- Division by zero, both signed and unsigned: uniform latency. lo = all ones, hi = a as originally presented (unmodified), div_by_zero = 1.
- Signed overflow (DIV of -2^(WIDTH-1) by -1): lo = -2^(WIDTH-1) (wraps), hi = 0. No flag.
- hi, lo and div_by_zero change only on the FIX->IDLE edge or on reset; otherwise they hold.
- done is registered, never combinational from start.

Test Plan:
1. WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done exactly 34 cycles after start edge; busy high for 33 cycles.
2. MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
3. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1. DIV a=7 b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
4. DIVU a=0x00001234 b=0 -> lo=0xFFFFFFFF, hi=0x00001234, div_by_zero=1. A following MULTU 2*3 -> lo=6, hi=0, div_by_zero=0.
5. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
6. Handshake and reset:
   - Pulse start again at cycle 5 of a MULTU 10*10 -> ignored, lo=100 at the single done.
   - Back-to-back start in the done cycle -> second result 34 cycles later.
   - Assert rst asynchronously at cycle 10 of an op -> busy=0, hi=lo=0 immediately, no done.
   - Repeat test 1 with WIDTH=8 (0xFF*0xFF -> hi=0xFE, lo=0x01, latency 10).
